// File: rtl/fft_bfly_stage11.sv
// Radix-2 DIF butterfly stage 11 of the 512-point streaming FFT (span 16).
// Even blocks are buffered as A. The following odd block is B, which produces
// the sum block S = A+B on the next cycle and the difference block D' on the
// cycle after that. D' is multiplied by -j when the block index mod 4 == 3.
module fft_bfly_stage11 #(
  parameter int IN_WIDTH  = 12,
  parameter int OUT_WIDTH = 15,
  parameter int NUM       = 16,
  parameter int DATA      = 32
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [NUM-1:0][IN_WIDTH-1:0]        din_i,
  input  logic [NUM-1:0][IN_WIDTH-1:0]        din_q,
  input  logic                                valid_in,
  output logic [NUM-1:0][OUT_WIDTH-1:0]       do1_re,
  output logic [NUM-1:0][OUT_WIDTH-1:0]       do1_im,
  output logic                                valid_out
);

  localparam int CW = $clog2(DATA);
  localparam int SW = IN_WIDTH + 1;
  localparam logic [CW-1:0] LAST_BLK = CW'(DATA - 1);

  logic [CW-1:0]                  blk_q, blk_d;
  logic [NUM-1:0][IN_WIDTH-1:0]   a_re_q, a_re_d, a_im_q, a_im_d;
  logic [NUM-1:0][OUT_WIDTH-1:0]  dif_re_q, dif_re_d, dif_im_q, dif_im_d;
  logic                           pend_q, pend_d;
  logic [NUM-1:0][OUT_WIDTH-1:0]  out_re_q, out_re_d, out_im_q, out_im_d;
  logic                           vout_q, vout_d;

  logic [NUM-1:0][OUT_WIDTH-1:0]  sum_re, sum_im, twd_re, twd_im;
  logic                           rot;

  // The -j twiddle applies to the second pair of every group of four blocks.
  assign rot = (blk_q[1:0] == 2'b11);

  // Per-lane butterfly: A comes from the buffer, B from the current input.
  // The arithmetic is done at IN_WIDTH+1 bits, which cannot overflow, and
  // then sign-extended to the output width.
  generate
    for (genvar gi = 0; gi < NUM; gi++) begin : g_lane
      logic signed [SW-1:0]        a_re_x, a_im_x, b_re_x, b_im_x;
      logic signed [SW-1:0]        s_re_x, s_im_x, d_re_x, d_im_x;
      logic signed [OUT_WIDTH-1:0] d_re_w, d_im_w;

      assign a_re_x = SW'($signed(a_re_q[gi]));
      assign a_im_x = SW'($signed(a_im_q[gi]));
      assign b_re_x = SW'($signed(din_i[gi]));
      assign b_im_x = SW'($signed(din_q[gi]));

      assign s_re_x = a_re_x + b_re_x;
      assign s_im_x = a_im_x + b_im_x;
      assign d_re_x = a_re_x - b_re_x;
      assign d_im_x = a_im_x - b_im_x;

      assign d_re_w = OUT_WIDTH'(d_re_x);
      assign d_im_w = OUT_WIDTH'(d_im_x);

      assign sum_re[gi] = OUT_WIDTH'(s_re_x);
      assign sum_im[gi] = OUT_WIDTH'(s_im_x);
      // (re + j*im) * (-j) = im - j*re
      assign twd_re[gi] = rot ? d_im_w : d_re_w;
      assign twd_im[gi] = rot ? -d_re_w : d_im_w;
    end
  endgenerate

  // Next-state logic for the block counter, the A buffer, the pending D' and the output registers.
  always_comb begin
    blk_d    = blk_q;
    a_re_d   = a_re_q;
    a_im_d   = a_im_q;
    dif_re_d = dif_re_q;
    dif_im_d = dif_im_q;
    pend_d   = 1'b0;
    out_re_d = out_re_q;
    out_im_d = out_im_q;
    vout_d   = 1'b0;

    // A held difference always goes out one cycle after its sum block.
    if (pend_q) begin
      out_re_d = dif_re_q;
      out_im_d = dif_im_q;
      vout_d   = 1'b1;
    end

    if (valid_in) begin
      blk_d = (blk_q == LAST_BLK) ? '0 : blk_q + 1'b1;
      if (!blk_q[0]) begin
        a_re_d = din_i;
        a_im_d = din_q;
      end else begin
        // An odd block never coincides with a pending D': the slot after
        // an odd block always holds an even block or an idle cycle.
        out_re_d = sum_re;
        out_im_d = sum_im;
        vout_d   = 1'b1;
        dif_re_d = twd_re;
        dif_im_d = twd_im;
        pend_d   = 1'b1;
      end
    end
  end

  // State registers; asynchronous reset discards any half-formed pair.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      blk_q    <= '0;
      a_re_q   <= '0;
      a_im_q   <= '0;
      dif_re_q <= '0;
      dif_im_q <= '0;
      pend_q   <= 1'b0;
      out_re_q <= '0;
      out_im_q <= '0;
      vout_q   <= 1'b0;
    end else begin
      blk_q    <= blk_d;
      a_re_q   <= a_re_d;
      a_im_q   <= a_im_d;
      dif_re_q <= dif_re_d;
      dif_im_q <= dif_im_d;
      pend_q   <= pend_d;
      out_re_q <= out_re_d;
      out_im_q <= out_im_d;
      vout_q   <= vout_d;
    end
  end

  assign do1_re    = out_re_q;
  assign do1_im    = out_im_q;
  assign valid_out = vout_q;

endmodule

// File: tb/tb_fft_bfly_stage11.sv
// Testbench for fft_bfly_stage11: table of uniform-lane pairs, reset and gap
// sequences, and two gap-free frames with per-lane random data.
module tb_fft_bfly_stage11;
  localparam int IW = 12;
  localparam int OW = 15;
  localparam int N  = 16;
  localparam int NB = 64;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic [N-1:0][IW-1:0]  din_i, din_q;
  logic                  valid_in;
  logic [N-1:0][OW-1:0]  do1_re, do1_im;
  logic                  valid_out;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string nm;
    int a_re, a_im, b_re, b_im;
    int s_re, s_im, d_re, d_im;
  } vec_t;

  vec_t vecs[6];
  int blk_re[NB][N];
  int blk_im[NB][N];

  fft_bfly_stage11 #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .NUM(N), .DATA(32)) dut (
    .clk(clk), .rstn(rstn), .din_i(din_i), .din_q(din_q), .valid_in(valid_in),
    .do1_re(do1_re), .do1_im(do1_im), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_all(input int re, input int im, input logic v);
    logic [IW-1:0] tr, ti;
    tr = IW'(re);
    ti = IW'(im);
    for (int j = 0; j < N; j++) begin
      din_i[j] = tr;
      din_q[j] = ti;
    end
    valid_in = v;
  endtask

  task automatic check_vo(input string nm, input logic exp);
    n_tests++;
    if (valid_out !== exp) begin
      n_fail++;
      $display("FAIL %s: valid_out=%0b expected %0b", nm, valid_out, exp);
    end else
      $display("[TB] ok %s valid_out=%0b", nm, valid_out);
  endtask

  task automatic check_uni(input string nm, input int er, input int ei);
    int bad;
    int gr, gi;
    bad = -1;
    gr = 0;
    gi = 0;
    for (int j = 0; j < N; j++) begin
      if (bad < 0 && (int'($signed(do1_re[j])) != er || int'($signed(do1_im[j])) != ei)) begin
        bad = j;
        gr = int'($signed(do1_re[j]));
        gi = int'($signed(do1_im[j]));
      end
    end
    n_tests++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: lane %0d got (%0d,%0d) expected (%0d,%0d)", nm, bad, gr, gi, er, ei);
    end else
      $display("[TB] ok %s (%0d,%0d) all lanes", nm, er, ei);
  endtask

  // Checks output block o of the random stream against a direct butterfly model.
  task automatic check_frame_out(input int o);
    int m, ka, kb, er, ei, sr, si, dr, di, bad, gr, gi;
    m  = o / 2;
    ka = 2 * m;
    kb = ka + 1;
    bad = -1;
    gr = 0; gi = 0; er = 0; ei = 0;
    for (int j = 0; j < N; j++) begin
      sr = blk_re[ka][j] + blk_re[kb][j];
      si = blk_im[ka][j] + blk_im[kb][j];
      dr = blk_re[ka][j] - blk_re[kb][j];
      di = blk_im[ka][j] - blk_im[kb][j];
      if (o % 2 == 0) begin
        er = sr; ei = si;
      end else if (m % 2 == 1) begin
        er = di; ei = -dr;
      end else begin
        er = dr; ei = di;
      end
      if (bad < 0 && (int'($signed(do1_re[j])) != er || int'($signed(do1_im[j])) != ei)) begin
        bad = j;
        gr = int'($signed(do1_re[j]));
        gi = int'($signed(do1_im[j]));
      end
    end
    n_tests++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL frame_out%0d: lane %0d got (%0d,%0d)", o, bad, gr, gi);
    end else
      $display("[TB] ok frame_out%0d", o);
  endtask

  initial begin
    vecs[0] = '{"p0_basic",   3, 1, 1, 2,  4, 3,  2, -1};
    vecs[1] = '{"p1_twid",    3, 1, 1, 2,  4, 3, -1, -2};
    vecs[2] = '{"p2_extreme", -2048, -2048, 2047, 2047, -1, -1, -4095, -4095};
    vecs[3] = '{"p3_ext_tw",  -2048, -2048, 2047, 2047, -1, -1, -4095, 4095};
    vecs[4] = '{"p4_mixed",   2047, -2048, -2048, 2047, -1, -1, 4095, -4095};
    vecs[5] = '{"p5_tw",      100, -7, -50, 20, 50, 13, -27, -150};

    // Reset held with valid_in active: nothing may come out.
    rstn = 1'b0;
    drive_all(3, 1, 1'b1);
    tick();
    tick();
    tick();
    check_vo("rst_vo", 1'b0);
    check_uni("rst_data", 0, 0);
    rstn = 1'b1;
    drive_all(0, 0, 1'b0);
    tick();
    check_vo("post_rst_idle", 1'b0);

    // Uniform-lane pairs; the first pair is blocks 0/1, so twiddles land on odd pairs.
    for (int k = 0; k < 6; k++) begin
      drive_all(vecs[k].a_re, vecs[k].a_im, 1'b1);
      tick();
      check_vo({vecs[k].nm, "_a"}, 1'b0);
      drive_all(vecs[k].b_re, vecs[k].b_im, 1'b1);
      tick();
      check_vo({vecs[k].nm, "_s_vo"}, 1'b1);
      check_uni({vecs[k].nm, "_s"}, vecs[k].s_re, vecs[k].s_im);
      drive_all(0, 0, 1'b0);
      tick();
      check_vo({vecs[k].nm, "_d_vo"}, 1'b1);
      check_uni({vecs[k].nm, "_d"}, vecs[k].d_re, vecs[k].d_im);
      tick();
      check_vo({vecs[k].nm, "_end"}, 1'b0);
    end

    // Asynchronous reset right after an S block clears outputs without a clock edge.
    drive_all(500, 500, 1'b1);
    tick();
    drive_all(1, 1, 1'b1);
    tick();
    check_uni("async_pre_s", 501, 501);
    drive_all(0, 0, 1'b0);
    #2 rstn = 1'b0;
    #1;
    check_vo("async_rst_vo", 1'b0);
    check_uni("async_rst_data", 0, 0);
    tick();
    rstn = 1'b1;

    // Reset mid-pair: the buffered even block is discarded, next block is block 0.
    drive_all(500, 500, 1'b1);
    tick();
    drive_all(0, 0, 1'b0);
    #2 rstn = 1'b0;
    #2 rstn = 1'b1;
    tick();
    drive_all(3, 1, 1'b1);
    tick();
    check_vo("midrst_a", 1'b0);
    drive_all(1, 2, 1'b1);
    tick();
    check_vo("midrst_s_vo", 1'b1);
    check_uni("midrst_s", 4, 3);
    drive_all(0, 0, 1'b0);
    tick();
    check_uni("midrst_d", 2, -1);

    // Gap between the two blocks of a pair (blocks 2/3, so D' carries -j).
    tick();
    drive_all(3, 1, 1'b1);
    tick();
    drive_all(0, 0, 1'b0);
    for (int g = 0; g < 3; g++) begin
      tick();
      check_vo("gap_idle", 1'b0);
    end
    drive_all(1, 2, 1'b1);
    tick();
    check_vo("gap_s_vo", 1'b1);
    check_uni("gap_s", 4, 3);
    drive_all(0, 0, 1'b0);
    tick();
    check_vo("gap_d_vo", 1'b1);
    check_uni("gap_d", -1, -2);
    tick();
    check_vo("gap_end", 1'b0);

    // Two gap-free frames with random per-lane data.
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    for (int b = 0; b < NB; b++)
      for (int j = 0; j < N; j++) begin
        blk_re[b][j] = int'($urandom_range(0, 4095)) - 2048;
        blk_im[b][j] = int'($urandom_range(0, 4095)) - 2048;
      end
    for (int i = 0; i <= NB + 1; i++) begin
      if (i < NB) begin
        for (int j = 0; j < N; j++) begin
          din_i[j] = IW'(blk_re[i][j]);
          din_q[j] = IW'(blk_im[i][j]);
        end
        valid_in = 1'b1;
      end else
        drive_all(0, 0, 1'b0);
      tick();
      if (i >= 1 && i <= NB) begin
        check_vo("frame_vo", 1'b1);
        check_frame_out(i - 1);
      end else
        check_vo("frame_vo_idle", 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
